sdram_arbiter: RTL
==================

# sdram_arbiter

Two-master arbiter sitting directly upstream of the SDRAM controller. Accepts single-word (32-bit) read/write requests from the N64 cartridge-bus side and the CPU side, serialises them into the SDRAM controller's request/busy/ack interface one transaction at a time, and routes completion and read data back to the originating master. Round-robin by default; optional fixed N64 priority.

## Interface
Parameters:
- N64_PRIORITY, 0, 0 = round-robin between masters; 1 = N64 always wins when both are pending.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_n64_request  in  1  one-cycle request pulse; honoured only while o_n64_busy=0.
- i_n64_write  in  1  1 = write, 0 = read; sampled with request.
- i_n64_address  in  25  SDRAM byte address; sampled with request.
- i_n64_data  in  32  write data; sampled with request.
- o_n64_busy  out  1  request pending or in flight.
- o_n64_ack  out  1  one-cycle completion pulse.
- o_n64_data  out  32  read data; valid with o_n64_ack, held until the next N64 ack.
- i_cpu_request, i_cpu_write, i_cpu_address, i_cpu_data, o_cpu_busy, o_cpu_ack, o_cpu_data: identical for the CPU master.
- o_mem_request  out  1  request to SDRAM controller.
- o_mem_write  out  1  write flag to controller.
- o_mem_address  out  25  address to controller.
- o_mem_data  out  32  write data to controller.
- i_mem_busy  in  1  controller busy; request accepted only on a cycle with o_mem_request=1 and i_mem_busy=0.
- i_mem_ack  in  1  controller completion pulse.
- i_mem_data  in  32  read data, valid with i_mem_ack.

## Operation
- Per master: pending flag plus latched write/address/data. An i_x_request while pending=0 sets pending and latches fields on the next edge. Requests while pending=1 are ignored. o_x_busy = pending.
- FSM states: IDLE, ISSUE, WAIT_ACK.
- IDLE: if any pending and i_mem_busy=0, select grant, load o_mem_* from the winner's latch, set owner, go to ISSUE. Otherwise stay.
- ISSUE: o_mem_request=1. If i_mem_busy=0, the request is accepted on this edge; go to WAIT_ACK. Else hold all o_mem_* unchanged and stay.
- WAIT_ACK: o_mem_request=0. On i_mem_ack: capture i_mem_data into owner's o_x_data if it was a read (writes leave o_x_data unchanged). Pulse owner's o_x_ack next cycle, clear owner's pending in that same cycle, record last_grant=owner, go to IDLE.
- Grant: single pending wins. Both pending: round-robin picks the master not equal to last_grant. With N64_PRIORITY=1, N64 wins.
- i_mem_ack in IDLE or ISSUE is ignored.
- Exactly one transaction outstanding at the controller at any time.

## Timing
- Reset (i_reset=0, async): state=IDLE, pending=0 for both, last_grant=CPU (first tie goes to N64), all o_* outputs 0 including o_x_data and o_mem_*. An in-flight controller ack arriving after reset release is ignored.
- Cycle 0: request pulse. Cycle 1: o_x_busy=1, FSM evaluates. Cycle 2: o_mem_request=1 (if i_mem_busy low). Minimum request-to-controller latency 2 cycles.
- i_mem_ack at cycle k -> o_x_ack=1, o_x_busy=0, o_x_data valid at cycle k+1. The next o_mem_request is no earlier than k+2.
- The master may issue a new request on the cycle its ack is high (busy already 0).
- A request from one master in the same cycle as the other master's ack is latched normally.
- o_mem_* fields are stable for the whole ISSUE state.

## Test plan
- Single N64 read: addr 0x0000100, controller acks 5 cycles after accept with 0xDEADBEEF -> o_mem_request at cycle 2, o_n64_ack one cycle after i_mem_ack, o_n64_data=0xDEADBEEF, busy low with ack.
- CPU write: addr 0x1FFFFFC, data 0x12345678 -> o_mem_write=1, correct addr/data on o_mem_*. o_cpu_ack pulses once; o_cpu_data unchanged (0).
- Both request same cycle, N64_PRIORITY=0, three rounds -> grant order N64, CPU, N64, CPU, N64, CPU. With N64_PRIORITY=1 and CPU continuously re-requesting, N64 is always granted first.
- i_mem_busy held high 4 cycles during ISSUE -> o_mem_request held with stable fields for 4 cycles, accepted on the 5th, single ack only.
- Second request pulse while busy, and spurious i_mem_ack in IDLE -> both ignored, no extra o_mem_request, no ack.
- Assert reset during WAIT_ACK, controller acks after release -> all outputs 0, no o_x_ack, pending cleared, next request served normally.

Source files
------------

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Two-master (N64 cartridge bus / CPU) arbiter in front of the
//               SDRAM controller. Each master posts one single-word read or
//               write at a time; the arbiter serialises them into the
//               controller's request/busy/ack handshake and routes the
//               completion pulse and read data back to the requester.
//               Round-robin on ties, or fixed N64 priority.
// Ports       : i_clk, i_reset (async, active-low)
//               i_n64_* / o_n64_* : N64 master request and response
//               i_cpu_* / o_cpu_* : CPU master request and response
//               o_mem_* / i_mem_* : SDRAM controller side
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
    parameter int N64_PRIORITY = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_n64_request,
    input  logic        i_n64_write,
    input  logic [24:0] i_n64_address,
    input  logic [31:0] i_n64_data,
    output logic        o_n64_busy,
    output logic        o_n64_ack,
    output logic [31:0] o_n64_data,

    input  logic        i_cpu_request,
    input  logic        i_cpu_write,
    input  logic [24:0] i_cpu_address,
    input  logic [31:0] i_cpu_data,
    output logic        o_cpu_busy,
    output logic        o_cpu_ack,
    output logic [31:0] o_cpu_data,

    output logic        o_mem_request,
    output logic        o_mem_write,
    output logic [24:0] o_mem_address,
    output logic [31:0] o_mem_data,
    input  logic        i_mem_busy,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_data
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_ISSUE    = 2'd1;
    localparam logic [1:0] c_ST_WAIT_ACK = 2'd2;

    localparam logic c_OWNER_N64 = 1'b0;
    localparam logic c_OWNER_CPU = 1'b1;

    logic [1:0]  r_state;
    logic        r_owner;
    logic        r_last_grant;

    logic        r_n64_pend;
    logic        r_n64_write;
    logic [24:0] r_n64_addr;
    logic [31:0] r_n64_wdata;
    logic        r_cpu_pend;
    logic        r_cpu_write;
    logic [24:0] r_cpu_addr;
    logic [31:0] r_cpu_wdata;

    logic        r_mem_request;
    logic        r_mem_write;
    logic [24:0] r_mem_address;
    logic [31:0] r_mem_data;
    logic        r_n64_ack;
    logic        r_cpu_ack;
    logic [31:0] r_n64_rdata;
    logic [31:0] r_cpu_rdata;

    logic        w_done;
    logic        w_n64_done;
    logic        w_cpu_done;
    logic        w_grant_cpu;

    // Completion edge: pending of the owner drops together with its ack pulse.
    assign w_done     = (r_state == c_ST_WAIT_ACK) && i_mem_ack;
    assign w_n64_done = w_done && (r_owner == c_OWNER_N64);
    assign w_cpu_done = w_done && (r_owner == c_OWNER_CPU);

    // CPU wins when alone, or on a tie when round-robin says it is its turn.
    assign w_grant_cpu = r_cpu_pend &&
                         (!r_n64_pend ||
                          ((N64_PRIORITY == 0) && (r_last_grant == c_OWNER_N64)));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_n64_pend  <= 1'b0;
            r_n64_write <= 1'b0;
            r_n64_addr  <= '0;
            r_n64_wdata <= '0;
        end else if (w_n64_done) begin
            r_n64_pend <= 1'b0;
        end else if (i_n64_request && !r_n64_pend) begin
            r_n64_pend  <= 1'b1;
            r_n64_write <= i_n64_write;
            r_n64_addr  <= i_n64_address;
            r_n64_wdata <= i_n64_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cpu_pend  <= 1'b0;
            r_cpu_write <= 1'b0;
            r_cpu_addr  <= '0;
            r_cpu_wdata <= '0;
        end else if (w_cpu_done) begin
            r_cpu_pend <= 1'b0;
        end else if (i_cpu_request && !r_cpu_pend) begin
            r_cpu_pend  <= 1'b1;
            r_cpu_write <= i_cpu_write;
            r_cpu_addr  <= i_cpu_address;
            r_cpu_wdata <= i_cpu_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= c_ST_IDLE;
            r_owner       <= c_OWNER_N64;
            r_last_grant  <= c_OWNER_CPU;  // first tie goes to N64
            r_mem_request <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_n64_ack     <= 1'b0;
            r_cpu_ack     <= 1'b0;
            r_n64_rdata   <= '0;
            r_cpu_rdata   <= '0;
        end else begin
            r_n64_ack <= 1'b0;
            r_cpu_ack <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if ((r_n64_pend || r_cpu_pend) && !i_mem_busy) begin
                        r_owner       <= w_grant_cpu;
                        r_mem_request <= 1'b1;
                        r_mem_write   <= w_grant_cpu ? r_cpu_write : r_n64_write;
                        r_mem_address <= w_grant_cpu ? r_cpu_addr  : r_n64_addr;
                        r_mem_data    <= w_grant_cpu ? r_cpu_wdata : r_n64_wdata;
                        r_state       <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    // Fields stay frozen until the controller takes the request.
                    if (!i_mem_busy) begin
                        r_mem_request <= 1'b0;
                        r_state       <= c_ST_WAIT_ACK;
                    end
                end
                c_ST_WAIT_ACK: begin
                    if (i_mem_ack) begin
                        if (r_owner == c_OWNER_CPU) begin
                            r_cpu_ack <= 1'b1;
                            if (!r_mem_write) r_cpu_rdata <= i_mem_data;
                        end else begin
                            r_n64_ack <= 1'b1;
                            if (!r_mem_write) r_n64_rdata <= i_mem_data;
                        end
                        r_last_grant <= r_owner;
                        r_state      <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign o_n64_busy    = r_n64_pend;
    assign o_n64_ack     = r_n64_ack;
    assign o_n64_data    = r_n64_rdata;
    assign o_cpu_busy    = r_cpu_pend;
    assign o_cpu_ack     = r_cpu_ack;
    assign o_cpu_data    = r_cpu_rdata;
    assign o_mem_request = r_mem_request;
    assign o_mem_write   = r_mem_write;
    assign o_mem_address = r_mem_address;
    assign o_mem_data    = r_mem_data;

endmodule
`default_nettype wire
